// File: rtl/adc_spi_ctrl.sv
// Serial front-end for a 12-bit SPI ADC. A free-running sample timer issues
// conversion ticks. Each tick runs one 16-bit SPI frame (SCLK idles high,
// data sampled on the rising edge) and publishes the low 12 bits on ADC_DATA
// with a one-cycle ADC_VALID strobe. Ticks that arrive mid-frame are dropped
// and latched in the sticky OVERRUN flag.
module adc_spi_ctrl #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        EN,
  input  logic        OVR_CLR,
  input  logic        ADC_SDO,
  output logic        ADC_SCLK,
  output logic        ADC_CSn,
  output logic [11:0] ADC_DATA,
  output logic        ADC_VALID,
  output logic        ADC_BUSY,
  output logic        OVERRUN
);

  localparam int unsigned TmrW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned PhW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TmrW-1:0] TmrLast = TmrW'(SAMPLE_PERIOD - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StQuiet
  } state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [PhW-1:0]    phase_q, phase_d;
  // SCLK half within a SHIFT period: 0 = low phase, 1 = high phase.
  logic              half_q, half_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       shift_q, shift_d;

  logic              sclk_q, sclk_d;
  logic              csn_q, csn_d;
  logic [11:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;

  logic              tick;
  logic              phase_last;

  // The four leading frame bits are shifted through but never used.
  logic              unused_lead_bits;
  assign unused_lead_bits = ^shift_q[15:12];

  assign tick       = EN && (tmr_q == '0);
  assign phase_last = (phase_q == PhLast);

  // Sample timer: cleared while disabled, counts modulo SAMPLE_PERIOD when enabled.
  always_comb begin
    tmr_d = tmr_q;
    if (!EN) begin
      tmr_d = '0;
    end else if (tmr_q == TmrLast) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TmrW'(1);
    end
  end

  // Frame sequencer: next state, phase/bit counters and shift register.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StSetup;
          phase_d = '0;
        end
      end

      StSetup: begin
        if (phase_last) begin
          state_d = StShift;
          phase_d = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end

      StShift: begin
        if (phase_last) begin
          phase_d = '0;
          if (!half_q) begin
            // End of low phase: SCLK rises on this edge, capture SDO with it.
            half_d  = 1'b1;
            shift_d = {shift_q[14:0], ADC_SDO};
          end else if (bit_q == 4'd15) begin
            state_d = StQuiet;
            half_d  = 1'b0;
          end else begin
            half_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end

      StQuiet: begin
        if (phase_last) begin
          state_d = StIdle;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    csn_d   = !((state_d == StSetup) || (state_d == StShift));
    sclk_d  = !((state_d == StShift) && !half_d);
    busy_d  = (state_d != StIdle);
    valid_d = (state_q == StShift) && (state_d == StQuiet);
    data_d  = valid_d ? shift_q[11:0] : data_q;

    // A tick that finds the sequencer busy is lost; setting beats clearing.
    ovr_d = ovr_q;
    if (tick && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end else if (OVR_CLR) begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      phase_q <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      csn_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ADC_SCLK  = sclk_q;
  assign ADC_CSn   = csn_q;
  assign ADC_DATA  = data_q;
  assign ADC_VALID = valid_q;
  assign ADC_BUSY  = busy_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Bench for adc_spi_ctrl: two instances (sample periods 100 and 40, CLK_DIV 2)
// driven by behavioural ADC models; expected samples are queued per frame.
module tb_adc_spi_ctrl;

  logic pclk    = 1'b0;
  logic presetn = 1'b1;

  logic en0 = 1'b0, clr0 = 1'b0, sdo0 = 1'b0;
  logic en1 = 1'b0, clr1 = 1'b0, sdo1 = 1'b0;
  logic sclk0, csn0, valid0, busy0, ovr0;
  logic sclk1, csn1, valid1, busy1, ovr1;
  logic [11:0] data0, data1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] frames0[$];
  logic [15:0] frames1[$];
  logic [11:0] exp0[$];
  logic [11:0] exp1[$];
  logic [15:0] cur0 = 16'h0, cur1 = 16'h0;
  int          idx0 = -1, idx1 = -1;

  always #5 pclk = ~pclk;

  adc_spi_ctrl #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) dut0 (
    .PCLK(pclk), .PRESETn(presetn), .EN(en0), .OVR_CLR(clr0), .ADC_SDO(sdo0),
    .ADC_SCLK(sclk0), .ADC_CSn(csn0), .ADC_DATA(data0), .ADC_VALID(valid0),
    .ADC_BUSY(busy0), .OVERRUN(ovr0)
  );

  adc_spi_ctrl #(.CLK_DIV(2), .SAMPLE_PERIOD(40)) dut1 (
    .PCLK(pclk), .PRESETn(presetn), .EN(en1), .OVR_CLR(clr1), .ADC_SDO(sdo1),
    .ADC_SCLK(sclk1), .ADC_CSn(csn1), .ADC_DATA(data1), .ADC_VALID(valid1),
    .ADC_BUSY(busy1), .OVERRUN(ovr1)
  );

  // ADC models: load a frame on CSn fall, present the next bit on each SCLK fall.
  always @(negedge csn0) begin
    cur0 = (frames0.size() > 0) ? frames0.pop_front() : 16'h0;
    idx0 = 15;
  end
  always @(negedge sclk0) begin
    if (!csn0 && idx0 >= 0) begin
      sdo0 = cur0[idx0];
      idx0--;
    end
  end
  always @(negedge csn1) begin
    cur1 = (frames1.size() > 0) ? frames1.pop_front() : 16'h0;
    idx1 = 15;
  end
  always @(negedge sclk1) begin
    if (!csn1 && idx1 >= 0) begin
      sdo1 = cur1[idx1];
      idx1--;
    end
  end

  task automatic test_reset();
    #1 presetn = 1'b0;
    #1;
    checks++; if (csn0 !== 1'b1) begin failures++; $display("FAIL reset_csn: got %b want 1", csn0); end
    checks++; if (sclk0 !== 1'b1) begin failures++; $display("FAIL reset_sclk: got %b want 1", sclk0); end
    checks++; if (data0 !== 12'h000) begin failures++; $display("FAIL reset_data: got %h want 000", data0); end
    checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", ovr0); end
    checks++; if (csn1 !== 1'b1 || sclk1 !== 1'b1 || ovr1 !== 1'b0) begin
      failures++; $display("FAIL reset_dut1: got csn=%b sclk=%b ovr=%b want 1 1 0", csn1, sclk1, ovr1);
    end
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    checks++; if (csn0 !== 1'b1 || busy0 !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: got csn=%b busy=%b want 1 0", csn0, busy0);
    end
  endtask

  task automatic test_single();
    int csn_first = -1, csn_last = -1, csn_cnt = 0;
    int falls = 0, rises = 0, fall_first = -1, fall_last = -1;
    int nvalid = 0, valid_at = -1, busy_low_at = -1, dchg = 0, dchg_at = -1;
    logic psclk = 1'b1;
    logic [11:0] pdata;
    logic [11:0] e;
    pdata = data0;
    frames0.push_back(16'h0A5C);
    exp0.push_back(12'hA5C);
    for (int k = 0; k <= 72; k++) begin
      @(negedge pclk);
      if (!csn0) begin
        if (csn_first < 0) csn_first = k;
        csn_last = k;
        csn_cnt++;
      end
      if (psclk && !sclk0) begin
        falls++;
        if (fall_first < 0) fall_first = k;
        fall_last = k;
      end
      if (!psclk && sclk0) rises++;
      psclk = sclk0;
      if (data0 !== pdata) begin dchg++; dchg_at = k; end
      pdata = data0;
      if (k > 1 && busy_low_at < 0 && !busy0) busy_low_at = k;
      if (valid0) begin
        nvalid++;
        valid_at = k;
        checks++;
        if (exp0.size() == 0) begin
          failures++; $display("FAIL single_data: got %h want none queued", data0);
        end else begin
          e = exp0.pop_front();
          if (data0 !== e) begin failures++; $display("FAIL single_data: got %h want %h", data0, e); end
        end
      end
      if (k == 0) en0 = 1'b1;
    end
    en0 = 1'b0;
    checks++; if (csn_first != 1) begin failures++; $display("FAIL csn_fall: got %0d want 1", csn_first); end
    checks++; if (csn_last != 66) begin failures++; $display("FAIL csn_rise: got %0d want 66", csn_last); end
    checks++; if (csn_cnt != 66) begin failures++; $display("FAIL csn_len: got %0d want 66", csn_cnt); end
    checks++; if (falls != 16 || rises != 16) begin
      failures++; $display("FAIL sclk_pulses: got falls=%0d rises=%0d want 16 16", falls, rises);
    end
    checks++; if (fall_first != 3 || fall_last != 63) begin
      failures++; $display("FAIL sclk_timing: got first=%0d last=%0d want 3 63", fall_first, fall_last);
    end
    checks++; if (nvalid != 1 || valid_at != 67) begin
      failures++; $display("FAIL single_valid: got n=%0d at=%0d want 1 at 67", nvalid, valid_at);
    end
    checks++; if (busy_low_at != 69) begin failures++; $display("FAIL busy_low: got %0d want 69", busy_low_at); end
    checks++; if (dchg != 1 || dchg_at != 67) begin
      failures++; $display("FAIL data_stable: got n=%0d at=%0d want 1 at 67", dchg, dchg_at);
    end
  endtask

  task automatic test_periodic();
    int vk[$];
    logic ovr_seen = 1'b0;
    logic [11:0] e;
    frames0.push_back(16'hFFFF);
    exp0.push_back(12'hFFF);
    frames0.push_back(16'h0001);
    exp0.push_back(12'h001);
    for (int k = 0; k <= 260; k++) begin
      @(negedge pclk);
      if (ovr0) ovr_seen = 1'b1;
      if (valid0) begin
        vk.push_back(k);
        checks++;
        if (exp0.size() == 0) begin
          failures++; $display("FAIL periodic_data: got %h want none queued", data0);
        end else begin
          e = exp0.pop_front();
          if (data0 !== e) begin failures++; $display("FAIL periodic_data: got %h want %h", data0, e); end
        end
      end
      if (k == 0) en0 = 1'b1;
      if (k == 180) en0 = 1'b0;
    end
    checks++; if (vk.size() != 2) begin
      failures++; $display("FAIL periodic_count: got %0d want 2", vk.size());
    end else if (vk[1] - vk[0] != 100) begin
      failures++; $display("FAIL periodic_spacing: got %0d want 100", vk[1] - vk[0]);
    end
    checks++; if (ovr_seen !== 1'b0) begin failures++; $display("FAIL periodic_ovr: got 1 want 0"); end
  endtask

  task automatic test_overrun();
    int vk[$];
    logic [11:0] e;
    frames1.push_back(16'h0123); exp1.push_back(12'h123);
    frames1.push_back(16'h0456); exp1.push_back(12'h456);
    frames1.push_back(16'h0789); exp1.push_back(12'h789);
    for (int k = 0; k <= 250; k++) begin
      @(negedge pclk);
      if (valid1) begin
        vk.push_back(k);
        checks++;
        if (exp1.size() == 0) begin
          failures++; $display("FAIL ovr_data: got %h want none queued", data1);
        end else begin
          e = exp1.pop_front();
          if (data1 !== e) begin failures++; $display("FAIL ovr_data: got %h want %h", data1, e); end
        end
      end
      if (k == 39) begin checks++; if (ovr1 !== 1'b0) begin failures++; $display("FAIL ovr_before: got %b want 0", ovr1); end end
      if (k == 41) begin checks++; if (ovr1 !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1", ovr1); end end
      if (k == 119) begin checks++; if (ovr1 !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", ovr1); end end
      if (k == 121) begin checks++; if (ovr1 !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %b want 1", ovr1); end end
      if (k == 131) begin checks++; if (ovr1 !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b want 0", ovr1); end end
      if (k == 201) begin checks++; if (ovr1 !== 1'b1) begin failures++; $display("FAIL ovr_reset: got %b want 1", ovr1); end end
      if (k == 0) en1 = 1'b1;
      if (k == 235) en1 = 1'b0;
      clr1 = (k == 120) || (k == 130);
    end
    clr1 = 1'b0;
    checks++; if (vk.size() != 3) begin
      failures++; $display("FAIL ovr_count: got %0d want 3", vk.size());
    end else if (vk[0] != 67 || vk[1] - vk[0] != 80 || vk[2] - vk[1] != 80) begin
      failures++; $display("FAIL ovr_spacing: got %0d %0d %0d want 67 147 227", vk[0], vk[1], vk[2]);
    end
  endtask

  task automatic test_en_drop();
    int nvalid = 0, valid_at = -1, csn_falls = 0;
    logic pcsn = 1'b1;
    logic [11:0] e;
    frames0.push_back(16'h0C3A);
    exp0.push_back(12'hC3A);
    for (int k = 0; k <= 250; k++) begin
      @(negedge pclk);
      if (pcsn && !csn0) csn_falls++;
      pcsn = csn0;
      if (valid0) begin
        nvalid++;
        valid_at = k;
        checks++;
        if (exp0.size() == 0) begin
          failures++; $display("FAIL endrop_data: got %h want none queued", data0);
        end else begin
          e = exp0.pop_front();
          if (data0 !== e) begin failures++; $display("FAIL endrop_data: got %h want %h", data0, e); end
        end
      end
      if (k == 0) en0 = 1'b1;
      if (k == 20) en0 = 1'b0;
    end
    checks++; if (nvalid != 1 || valid_at != 67) begin
      failures++; $display("FAIL endrop_valid: got n=%0d at=%0d want 1 at 67", nvalid, valid_at);
    end
    checks++; if (csn_falls != 1) begin failures++; $display("FAIL endrop_csn: got %0d want 1", csn_falls); end
    checks++; if (dut0.tmr_q !== '0) begin failures++; $display("FAIL endrop_tmr: got %0d want 0", dut0.tmr_q); end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0, valid_at = -1;
    logic early_valid = 1'b0;
    logic [11:0] e;
    frames0.push_back(16'h0777);  // lost to reset, no expectation queued
    frames0.push_back(16'h0ABC);
    exp0.push_back(12'hABC);
    for (int k = 0; k <= 30; k++) begin
      @(negedge pclk);
      if (valid0) early_valid = 1'b1;
      if (k == 0) en0 = 1'b1;
    end
    checks++; if (csn0 !== 1'b0) begin failures++; $display("FAIL mid_frame_active: got csn=%b want 0", csn0); end
    presetn = 1'b0;
    #1;
    checks++; if (csn0 !== 1'b1 || sclk0 !== 1'b1) begin
      failures++; $display("FAIL async_reset: got csn=%b sclk=%b want 1 1", csn0, sclk0);
    end
    checks++; if (data0 !== 12'h000 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL reset_clear: got data=%h valid=%b busy=%b want 000 0 0", data0, valid0, busy0);
    end
    repeat (3) begin
      @(negedge pclk);
      if (valid0) early_valid = 1'b1;
    end
    presetn = 1'b1;
    for (int r = 1; r <= 75; r++) begin
      @(negedge pclk);
      if (r == 1) begin
        checks++; if (csn0 !== 1'b0) begin failures++; $display("FAIL restart_csn: got %b want 0", csn0); end
      end
      if (r == 66) begin
        checks++; if (data0 !== 12'h000) begin failures++; $display("FAIL data_held_zero: got %h want 000", data0); end
      end
      if (valid0) begin
        nvalid++;
        valid_at = r;
        checks++;
        if (exp0.size() == 0) begin
          failures++; $display("FAIL restart_data: got %h want none queued", data0);
        end else begin
          e = exp0.pop_front();
          if (data0 !== e) begin failures++; $display("FAIL restart_data: got %h want %h", data0, e); end
        end
      end
    end
    en0 = 1'b0;
    checks++; if (early_valid !== 1'b0) begin failures++; $display("FAIL reset_no_valid: got 1 want 0"); end
    checks++; if (nvalid != 1 || valid_at != 67) begin
      failures++; $display("FAIL restart_valid: got n=%0d at=%0d want 1 at 67", nvalid, valid_at);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_periodic();
    test_overrun();
    test_en_drop();
    test_reset_mid();
    repeat (5) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_ctrl.md
# adc_spi_ctrl

Serial front-end for the 12-bit SPI ADC, placed directly upstream of the APB ADC read port. It issues conversions at a fixed programmable rate, clocks the 16-bit ADC frame in (4 leading zeros, then 12 data bits, MSB first), and holds the latest sample on `ADC_DATA` for the APB side to capture. It also flags sample ticks that are lost because a conversion is still in progress.

## Interface
- `CLK_DIV`, default 4: PCLK cycles per SCLK half-period; legal range ≥ 2.
- `SAMPLE_PERIOD`, default 1000: PCLK cycles between conversion ticks; legal range ≥ 2.
- `PCLK` in 1: system clock. Single clock domain.
- `PRESETn` in 1: asynchronous, active-low reset.
- `EN` in 1: enables the sample timer.
- `OVR_CLR` in 1: single-cycle pulse that clears `OVERRUN`.
- `ADC_SDO` in 1: serial data from the ADC. The ADC changes it on SCLK falling edges.
- `ADC_SCLK` out 1: serial clock. Idles high.
- `ADC_CSn` out 1: ADC chip select, active low.
- `ADC_DATA` out 12: latest completed sample. Held stable between updates.
- `ADC_VALID` out 1: one-cycle pulse marking an `ADC_DATA` update.
- `ADC_BUSY` out 1: high whenever the FSM is not in IDLE.
- `OVERRUN` out 1: sticky flag for a skipped conversion tick.

## Operation
- **Sample timer `tmr`**
  - Held at 0 while `EN` = 0.
  - While `EN` = 1, increments each cycle and wraps from `SAMPLE_PERIOD`−1 to 0.
  - `tick` = `EN` & (`tmr` == 0). The first tick occurs in the first cycle `EN` is seen high.
- **FSM states:** IDLE, SETUP, SHIFT, QUIET. All outputs are registered.
  - **IDLE:** `ADC_CSn`=1, `ADC_SCLK`=1. On `tick` → SETUP.
  - **SETUP:** `ADC_CSn`=0, `ADC_SCLK`=1, for `CLK_DIV` cycles → SHIFT.
  - **SHIFT:** 16 SCLK periods. Each period is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
    - `ADC_SDO` is shifted into a 16-bit register (left shift, LSB in) on the PCLK edge that raises SCLK.
    - Bit counter runs 0..15. After the 16th high phase → QUIET.
  - **QUIET:** `ADC_CSn`=1, `ADC_SCLK`=1, for `CLK_DIV` cycles → IDLE.
    - On the entry cycle: `ADC_DATA` ← `shift[11:0]` and `ADC_VALID`=1.
    - The 4 leading bits are discarded without checking.
- **`EN` dropped mid-frame:** the frame completes normally. No new tick is generated.
- **`tick` while not IDLE:** the tick is discarded and `OVERRUN` is set.
  - The next conversion starts on the next tick that arrives in IDLE.
- **`OVERRUN` clear:** `OVR_CLR` clears it. If set and clear happen in the same cycle, set wins.
- **Arithmetic sizing:**
  - `tmr`: `$clog2(SAMPLE_PERIOD)` bits.
  - Phase counter: `$clog2(CLK_DIV)` bits.
  - Bit counter: 4 bits (wraps only via a state change, never arithmetically).

## Timing
- **Reset values:** `ADC_CSn`=1, `ADC_SCLK`=1, `ADC_DATA`=0, `ADC_VALID`=0, `ADC_BUSY`=0, `OVERRUN`=0. Also `tmr`=0, FSM=IDLE, shift register=0.
- **Reset mid-frame:** all of the above take effect immediately. The partial frame is lost and `ADC_DATA` is not updated.
- **Cycle timeline**, with the tick in cycle t:
  - `ADC_CSn` falls at t+1.
  - First SCLK falling edge at t+1+`CLK_DIV`.
  - `ADC_VALID` high and `ADC_CSn` high at t+1+33·`CLK_DIV`.
  - `ADC_BUSY` low at t+1+34·`CLK_DIV`.
  - `ADC_CSn` is low for exactly 33·`CLK_DIV` cycles.
- **Minimum overrun-free period:** `SAMPLE_PERIOD` ≥ 34·`CLK_DIV`+1. Smaller values are legal but skip ticks and set `OVERRUN`.
- **`ADC_DATA` stability:** changes only in the `ADC_VALID` cycle. It is stable for at least 34·`CLK_DIV` cycles after each update, so the APB side may sample it at any time.
- **`ADC_SDO` timing:** sampled `CLK_DIV` PCLK cycles after the falling SCLK edge. No synchronizer is used; `CLK_DIV` ≥ 2 provides setup margin.

## Test plan
- **Single conversion** (`CLK_DIV`=2, `SAMPLE_PERIOD`=100): ADC model drives frame 16'h0A5C; assert `EN` at cycle t. Required: `ADC_CSn` low t+1..t+66; 16 SCLK pulses of period 4; `ADC_VALID` pulse at t+67; `ADC_DATA`=12'hA5C; `ADC_BUSY` low at t+69.
- **Periodic sampling and bit masking:** frames 16'hFFFF then 16'h0001. Required: `ADC_DATA`=12'hFFF, then 12'h001; the two `ADC_VALID` pulses are exactly 100 cycles apart; `OVERRUN`=0.
- **Overrun** (`CLK_DIV`=2, `SAMPLE_PERIOD`=40): Required: every second tick is skipped, `OVERRUN`=1 after the 2nd tick, `ADC_VALID` pulses are 80 cycles apart. Pulse `OVR_CLR` in the same cycle as a skipped tick: `OVERRUN` stays 1.
- **`EN` dropped mid-frame:** deassert `EN` at t+20. Required: the frame completes with `ADC_VALID` at t+67; no further `ADC_CSn` activity; `tmr` reads 0.
- **Reset mid-frame:** assert `PRESETn`=0 at t+30. Required: `ADC_CSn`=1 and `ADC_SCLK`=1 immediately (asynchronously); `ADC_DATA`=0; no `ADC_VALID`. After release with `EN`=1, a fresh conversion starts in the first cycle.
